clkdiv_sweep_ctrl: RTL

- Sequencer for the team's programmable clock divider.
- Drives the divider's max-count input and its reset.
- Steps the divide value from a start value to an end value in fixed increments.
- Dwells a programmable number of divided-clock toggles at each value, then holds the final value.
- Used for tone sweeps and PWM carrier ramps without CPU/pin intervention per step.

---
 rtl/clkdiv_sweep_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/clkdiv_sweep_ctrl.sv
// Sweep sequencer for the programmable clock divider: steps div_max_o from start to end,
// dwelling a set number of divided-clock toggles per value. Define CLKDIV_SWEEP_PINGPONG_EN for endless ping-pong.
//
// state | meaning
// IDLE  | divider held in reset, waiting for start
// LOAD  | one cycle, divider reset with the first value applied
// RUN   | divider running, dwell counting and stepping
// HOLD  | final value reached, divider keeps running
module clkdiv_sweep_ctrl #(
  parameter int BW = 8,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [BW-1:0] start_val_i,
  input  logic [BW-1:0] end_val_i,
  input  logic [BW-1:0] step_i,
  input  logic [DW-1:0] dwell_i,
  input  logic          div_clk_i,
  output logic [BW-1:0] div_max_o,
  output logic          div_rst_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]    state;
  logic [BW-1:0] end_q;
  logic [BW-1:0] step_q;
  logic [DW-1:0] dwell_q;
  logic [DW-1:0] cnt;
  logic          dir_q;
  logic          div_clk_q;
  logic          tog;
  logic [BW-1:0] nxt;
`ifdef CLKDIV_SWEEP_PINGPONG_EN
  logic [BW-1:0] start_q;
  logic [BW-1:0] nxt_pp;
`endif

  // Step one increment toward target; any overshoot, carry or borrow clamps to target.
  function automatic logic [BW-1:0] next_val(input logic [BW-1:0] cur, input logic [BW-1:0] step,
                                             input logic [BW-1:0] target, input logic down);
    logic [BW:0] res;
    logic [BW:0] tgt;
    tgt = {1'b0, target};
    if (down) begin
      res = {1'b0, cur} - {1'b0, step};
      if (step == '0 || res[BW] || res < tgt) return target;
    end else begin
      res = {1'b0, cur} + {1'b0, step};
      if (step == '0 || res > tgt) return target;
    end
    return res[BW-1:0];
  endfunction

  assign tog = div_clk_i ^ div_clk_q;

  always_comb begin
    nxt = next_val(div_max_o, step_q, end_q, dir_q);
`ifdef CLKDIV_SWEEP_PINGPONG_EN
    nxt_pp = next_val(div_max_o, step_q, start_q, ~dir_q);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      div_max_o <= '0;
      div_rst_o <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      cnt       <= '0;
      div_clk_q <= 1'b0;
      end_q     <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      dir_q     <= 1'b0;
`ifdef CLKDIV_SWEEP_PINGPONG_EN
      start_q   <= '0;
`endif
    end else begin
      div_clk_q <= (state == LOAD) ? 1'b0 : div_clk_i;
      done_o    <= 1'b0;
      if (abort_i) begin
        state     <= IDLE;
        div_rst_o <= 1'b1;
        busy_o    <= 1'b0;
      end else begin
        case (state)
          IDLE, HOLD: begin
            if (start_i) begin
              state     <= LOAD;
              div_max_o <= start_val_i;
              end_q     <= end_val_i;
              step_q    <= step_i;
              dwell_q   <= (dwell_i == '0) ? DW'(1) : dwell_i;
              dir_q     <= (start_val_i > end_val_i);
`ifdef CLKDIV_SWEEP_PINGPONG_EN
              start_q   <= start_val_i;
`endif
              div_rst_o <= 1'b1;
              busy_o    <= 1'b1;
            end
          end
          LOAD: begin
            state     <= RUN;
            cnt       <= '0;
            div_rst_o <= 1'b0;
          end
          RUN: begin
            if (tog) begin
              if (cnt == dwell_q - DW'(1)) begin
                cnt <= '0;
                if (div_max_o == end_q) begin
                  done_o <= 1'b1;
`ifdef CLKDIV_SWEEP_PINGPONG_EN
                  // Reverse in place: the old start becomes the new target.
                  start_q   <= end_q;
                  end_q     <= start_q;
                  dir_q     <= ~dir_q;
                  div_max_o <= nxt_pp;
`else
                  state  <= HOLD;
                  busy_o <= 1'b0;
`endif
                end else begin
                  div_max_o <= nxt;
                end
              end else begin
                cnt <= cnt + DW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
